// File: rtl/result_unpacker.sv
// result_unpacker: splits one 90-bit packed result vector into 18 field beats.
// Latency: first beat one cycle after acceptance; 18 beats per vector, no bubble between vectors.
// Backpressure: beats hold stable while out_ready is low; a new vector is taken only when idle or with the final beat.
//
// Ports:
//   clk, reset                     clock and synchronous active-high reset
//   in_valid/in_ready/in_data      packed vector {f0..f17}, f0 in the MSBs
//   out_valid/out_ready            per-field beat handshake
//   out_idx/out_width/out_signed   field index, width (4/5/6) and signedness
//   out_data/out_last              field value extended to 8 bits; last marks field 17
//   vec_count                      vectors accepted since reset (wraps)
//   out_chk                        XOR of out_data over the vector, present only
//                                  when RESULT_UNPACKER_CHECKSUM_EN is defined
module result_unpacker (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [89:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_idx,
  output logic [2:0]  out_width,
  output logic        out_signed,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic [15:0] vec_count
`ifdef RESULT_UNPACKER_CHECKSUM_EN
  ,
  output logic [7:0]  out_chk
`endif
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t       state_q, state_d;
  logic [89:0]  hold_q, hold_d;
  logic [4:0]   idx_q, idx_d;
  logic [15:0]  cnt_q, cnt_d;

  logic         accept;
  logic         beat;
  logic         last;
  logic [4:0]   grp;
  logic [1:0]   rem;
  logic [6:0]   off;
  logic [6:0]   lsb;
  logic [2:0]   fw;
  logic         sgn;
  logic [5:0]   field;
  logic [7:0]   ext;

  // Field geometry: group of three fields every 15 bits, widths 4/5/6 inside a
  // group; odd groups (k%6 in 3..5) are signed.
  always_comb begin
    grp   = idx_q / 5'd3;
    rem   = 2'(idx_q % 5'd3);
    fw    = 3'd4 + {1'b0, rem};
    sgn   = grp[0];
    case (rem)
      2'd0:    off = 7'd0;
      2'd1:    off = 7'd4;
      default: off = 7'd9;
    endcase
    // lsb = msb - width + 1 with msb = 89 - 15*g - off
    lsb   = 7'd90 - (7'd15 * {2'b00, grp}) - off - {4'b0000, fw};
    field = 6'(hold_q >> lsb);
    case (fw)
      3'd4:    ext = sgn ? {{4{field[3]}}, field[3:0]} : {4'b0000, field[3:0]};
      3'd5:    ext = sgn ? {{3{field[4]}}, field[4:0]} : {3'b000, field[4:0]};
      default: ext = sgn ? {{2{field[5]}}, field[5:0]} : {2'b00, field[5:0]};
    endcase
  end

  assign out_valid = (state_q == EMIT);
  assign last      = (idx_q == 5'd17);
  assign beat      = out_valid && out_ready;
  assign in_ready  = !reset && ((state_q == IDLE) || (beat && last));
  assign accept    = in_valid && in_ready;

  // Field outputs read zero whenever no beat is offered, so reset and idle
  // present a clean all-zero bus.
  assign out_idx    = idx_q;
  assign out_width  = out_valid ? fw  : 3'd0;
  assign out_signed = out_valid ? sgn : 1'b0;
  assign out_data   = out_valid ? ext : 8'd0;
  assign out_last   = out_valid && last;
  assign vec_count  = cnt_q;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    // A new vector wins over the end-of-vector transition, giving the
    // back-to-back handover with no bubble.
    if (accept) begin
      state_d = EMIT;
      hold_d  = in_data;
      idx_d   = 5'd0;
      cnt_d   = cnt_q + 16'd1;
    end else if (beat) begin
      if (last) begin
        state_d = IDLE;
        idx_d   = 5'd0;
      end else begin
        idx_d   = idx_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef RESULT_UNPACKER_CHECKSUM_EN
  // chk_q accumulates the beats already delivered; folding in the current
  // beat makes out_chk complete exactly when field 17 is on the bus.
  logic [7:0] chk_q, chk_d;

  always_comb begin
    chk_d = chk_q;
    if (accept)    chk_d = 8'd0;
    else if (beat) chk_d = chk_q ^ out_data;
  end

  always_ff @(posedge clk) begin
    if (reset) chk_q <= '0;
    else       chk_q <= chk_d;
  end

  assign out_chk = chk_q ^ out_data;
`endif

endmodule
